// File: rtl/hazard_pkg.sv
// Shared types and default sizes for the pipeline hazard controller.
package hazard_pkg;

  localparam int CNT_W_DEF    = 16;
  localparam int MAX_WAIT_DEF = 64;

  // Controller state; encoding 2'd3 is unused and recovers to RUN.
  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LU_BUBBLE = 2'd1,
    MEM_WAIT  = 2'd2
  } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// Load-use comparator: the load in EX targets a register that the ID
// instruction reads. r0 is never a real dependency.
module load_use_detect (
  input  logic       i_ex_mem_read,
  input  logic       i_ex_write_reg,
  input  logic [3:0] i_ex_rd,
  input  logic [3:0] i_id_rs,
  input  logic [3:0] i_id_rt,
  input  logic       i_id_uses_rs,
  input  logic       i_id_uses_rt,
  output logic       o_lu
);

  logic w_load_valid;
  logic w_rs_match;
  logic w_rt_match;

  assign w_load_valid = i_ex_mem_read && i_ex_write_reg && (i_ex_rd != 4'd0);
  assign w_rs_match   = i_id_uses_rs && (i_id_rs == i_ex_rd);
  assign w_rt_match   = i_id_uses_rt && (i_id_rt == i_ex_rd);
  assign o_lu         = w_load_valid && (w_rs_match || w_rt_match);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller. Stall/flush outputs are Mealy and drive the
// pipeline-register enables directly; priority is mem_busy, load-use, branch.
// Reset forces every register to load a bubble (all enables and flushes high).
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       id_rs,
  input  logic [3:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [3:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_WriteReg,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pc_stall_n,
  output logic             if_id_stall_n,
  output logic             id_ex_stall_n,
  output logic             ex_mem_stall_n,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [CNT_W-1:0] stall_count,
  output logic             mem_timeout,
  output logic [1:0]       hz_state
);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [31:0]      MAX_WAIT_U = 32'(MAX_WAIT);

  hz_state_t        r_state;
  hz_state_t        w_next_state;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_timeout;

  logic             w_lu;
  logic             w_lu_eff;
  logic             w_illegal;
  logic             w_pc_stall_n;
  logic             w_if_id_stall_n;
  logic             w_id_ex_stall_n;
  logic             w_ex_mem_stall_n;
  logic             w_if_id_flush;
  logic             w_id_ex_flush;
  logic [31:0]      w_wait_inc;
  logic             w_wait_hit;

  load_use_detect u_lu (
    .i_ex_mem_read (ex_mem_read),
    .i_ex_write_reg(ex_WriteReg),
    .i_ex_rd       (ex_rd),
    .i_id_rs       (id_rs),
    .i_id_rt       (id_rt),
    .i_id_uses_rs  (id_uses_rs),
    .i_id_uses_rt  (id_uses_rt),
    .o_lu          (w_lu)
  );

  // In LU_BUBBLE the EX stage already holds the bubble, so the comparator
  // still sees the stale load and must be ignored for one cycle.
  assign w_illegal = (2'(r_state) == 2'd3);
  assign w_lu_eff  = w_lu && (r_state != LU_BUBBLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_next_state;
  end

  // Next-state and Mealy stall/flush outputs, highest priority first.
  always_comb begin
    w_next_state     = RUN;
    w_pc_stall_n     = 1'b1;
    w_if_id_stall_n  = 1'b1;
    w_id_ex_stall_n  = 1'b1;
    w_ex_mem_stall_n = 1'b1;
    w_if_id_flush    = 1'b0;
    w_id_ex_flush    = 1'b0;
    if (rst) begin
      w_if_id_flush = 1'b1;
      w_id_ex_flush = 1'b1;
    end else if (mem_busy) begin
      w_pc_stall_n     = 1'b0;
      w_if_id_stall_n  = 1'b0;
      w_id_ex_stall_n  = 1'b0;
      w_ex_mem_stall_n = 1'b0;
      w_next_state     = MEM_WAIT;
    end else if (w_lu_eff) begin
      w_pc_stall_n    = 1'b0;
      w_if_id_stall_n = 1'b0;
      w_id_ex_flush   = 1'b1;
      w_next_state    = LU_BUBBLE;
    end else if (branch_taken) begin
      w_if_id_flush = 1'b1;
    end
    if (w_illegal) w_next_state = RUN;
  end

  // Saturating count of cycles in which the PC is held.
  always_ff @(posedge clk) begin
    if (rst)                                        r_stall_cnt <= '0;
    else if (!w_pc_stall_n && r_stall_cnt != CNT_MAX) r_stall_cnt <= r_stall_cnt + CNT_ONE;
  end

  assign w_wait_inc = 32'(r_wait_cnt) + 32'd1;
  assign w_wait_hit = (w_wait_inc >= MAX_WAIT_U);

  // Consecutive mem_busy counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else if (mem_busy) begin
      if (r_wait_cnt != CNT_MAX) r_wait_cnt <= r_wait_cnt + CNT_ONE;
      if (w_wait_hit)            r_timeout  <= 1'b1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  assign pc_stall_n     = w_pc_stall_n;
  assign if_id_stall_n  = w_if_id_stall_n;
  assign id_ex_stall_n  = w_id_ex_stall_n;
  assign ex_mem_stall_n = w_ex_mem_stall_n;
  assign if_id_flush    = w_if_id_flush;
  assign id_ex_flush    = w_id_ex_flush;
  assign stall_count    = r_stall_cnt;
  assign mem_timeout    = r_timeout;
  assign hz_state       = 2'(r_state);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a hand-derived vector table, directed multi-cycle
// sequences and randomized cycles checked against a history-based model.
module tb_hazard_ctrl;

  typedef struct {
    logic       rst;
    logic [3:0] rs;
    logic [3:0] rt;
    logic       urs;
    logic       urt;
    logic [3:0] rd;
    logic       mr;
    logic       wr;
    logic       br;
    logic       busy;
  } stim_t;

  typedef struct {
    stim_t      s;
    logic [5:0] exp_out;
    logic [1:0] exp_hz;
    int         exp_cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst, id_uses_rs, id_uses_rt, ex_mem_read, ex_WriteReg, branch_taken, mem_busy;
  logic [3:0] id_rs, id_rt, ex_rd;

  logic pc_n, ifid_n, idex_n, exmem_n, ifid_fl, idex_fl, to;
  logic [15:0] cnt;
  logic [1:0] hz;
  logic s_pc_n, s_ifid_n, s_idex_n, s_exmem_n, s_ifid_fl, s_idex_fl, s_to;
  logic [3:0] s_cnt;
  logic [1:0] s_hz;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_WriteReg(ex_WriteReg),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_stall_n(pc_n), .if_id_stall_n(ifid_n), .id_ex_stall_n(idex_n),
    .ex_mem_stall_n(exmem_n), .if_id_flush(ifid_fl), .id_ex_flush(idex_fl),
    .stall_count(cnt), .mem_timeout(to), .hz_state(hz)
  );

  hazard_ctrl #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_WriteReg(ex_WriteReg),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_stall_n(s_pc_n), .if_id_stall_n(s_ifid_n), .id_ex_stall_n(s_idex_n),
    .ex_mem_stall_n(s_exmem_n), .if_id_flush(s_ifid_fl), .id_ex_flush(s_idex_fl),
    .stall_count(s_cnt), .mem_timeout(s_to), .hz_state(s_hz)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: history of what happened in the previous cycle.
  bit m_known = 0;
  bit m_prev_busy = 0;
  bit m_prev_lu_stall = 0;
  int m_stalls = 0;
  int m_busy_run = 0;
  bit m_timeout = 0;

  // Values sampled in the most recent cycle.
  logic [5:0] a_out;
  logic [1:0] a_hz;
  logic [15:0] a_cnt;
  logic [3:0] a_cnt_sat;
  logic a_to;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic stim_t mk(input logic r, input logic [3:0] rs, input logic [3:0] rt,
                               input logic urs, input logic urt, input logic [3:0] rd,
                               input logic mr, input logic wr, input logic br, input logic busy);
    stim_t s;
    s.rst = r; s.rs = rs; s.rt = rt; s.urs = urs; s.urt = urt;
    s.rd = rd; s.mr = mr; s.wr = wr; s.br = br; s.busy = busy;
    return s;
  endfunction

  function automatic bit m_lu(input stim_t s);
    bit dep;
    dep = (s.urs && s.rs == s.rd) || (s.urt && s.rt == s.rd);
    return s.mr && s.wr && (s.rd != 0) && dep;
  endfunction

  // Expected {pc, if_id, id_ex, ex_mem stall_n, if_id_flush, id_ex_flush}.
  function automatic logic [5:0] m_out(input stim_t s);
    if (s.rst) return 6'b111111;
    if (s.busy) return 6'b000000;
    if (m_lu(s) && !m_prev_lu_stall) return 6'b001101;
    if (s.br) return 6'b111110;
    return 6'b111100;
  endfunction

  function automatic int clamp(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_update(input stim_t s, input logic [5:0] o);
    if (s.rst) begin
      m_known = 1; m_prev_busy = 0; m_prev_lu_stall = 0;
      m_stalls = 0; m_busy_run = 0; m_timeout = 0;
    end else begin
      if (o[5] == 1'b0) m_stalls++;
      m_busy_run = s.busy ? m_busy_run + 1 : 0;
      if (m_busy_run >= 64) m_timeout = 1;
      m_prev_lu_stall = !s.busy && m_lu(s) && !m_prev_lu_stall;
      m_prev_busy = s.busy;
    end
  endtask

  // One clock cycle: drive at the falling edge, sample 2 ns later,
  // compare against the model, then advance the model past the next edge.
  task automatic cycle(input stim_t s);
    logic [5:0] e;
    @(negedge clk);
    rst = s.rst; id_rs = s.rs; id_rt = s.rt; id_uses_rs = s.urs; id_uses_rt = s.urt;
    ex_rd = s.rd; ex_mem_read = s.mr; ex_WriteReg = s.wr; branch_taken = s.br; mem_busy = s.busy;
    #2;
    a_out = {pc_n, ifid_n, idex_n, exmem_n, ifid_fl, idex_fl};
    a_hz = hz; a_cnt = cnt; a_cnt_sat = s_cnt; a_to = to;
    e = m_out(s);
    chk("model_outputs", 32'(a_out), 32'(e));
    chk("model_outputs_sat", 32'({s_pc_n, s_ifid_n, s_idex_n, s_exmem_n, s_ifid_fl, s_idex_fl}), 32'(e));
    if (m_known) begin
      chk("model_hz_state", 32'(a_hz), m_prev_busy ? 32'd2 : (m_prev_lu_stall ? 32'd1 : 32'd0));
      chk("model_stall_count", 32'(a_cnt), 32'(clamp(m_stalls, 65535)));
      chk("model_stall_count_sat", 32'(a_cnt_sat), 32'(clamp(m_stalls, 15)));
      chk("model_mem_timeout", 32'(a_to), 32'(m_timeout));
    end
    model_update(s, e);
  endtask

  task automatic add(input stim_t s, input logic [5:0] o, input logic [1:0] h, input int c);
    vec_t v;
    v.s = s; v.exp_out = o; v.exp_hz = h; v.exp_cnt = c;
    tbl.push_back(v);
  endtask

  stim_t IDLE, L, LB, BUSY, RST;

  initial begin
    IDLE = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    L    = mk(0, 5, 0, 1, 0, 5, 1, 1, 0, 0);
    LB   = mk(0, 5, 0, 1, 0, 5, 1, 1, 0, 1);
    BUSY = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    RST  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Hand-derived table, applied in order right after a reset.
    add(mk(1, 5, 0, 1, 0, 5, 1, 1, 1, 1), 6'b111111, 2'd0, 0); // rst overrides busy/lu
    add(mk(0, 0, 0, 1, 0, 0, 1, 1, 0, 0), 6'b111100, 2'd0, 0); // r0 exempt
    add(IDLE,                             6'b111100, 2'd0, 0);
    add(L,                                6'b001101, 2'd0, 0); // load-use
    add(L,                                6'b111100, 2'd1, 1); // bubble, lu ignored
    add(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 6'b111110, 2'd0, 1); // taken branch
    add(IDLE,                             6'b111100, 2'd0, 1);
    add(mk(0, 0, 7, 0, 1, 7, 1, 1, 1, 0), 6'b001101, 2'd0, 1); // branch + lu on rt
    add(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 6'b111110, 2'd1, 2); // branch in bubble
    add(mk(0, 5, 0, 1, 0, 5, 1, 0, 0, 0), 6'b111100, 2'd0, 2); // no write-back
    add(mk(0, 5, 0, 0, 0, 5, 1, 1, 0, 0), 6'b111100, 2'd0, 2); // rs not used
    add(mk(0, 5, 0, 1, 0, 5, 1, 1, 1, 1), 6'b000000, 2'd0, 2); // busy beats all
    add(BUSY,                             6'b000000, 2'd2, 3);
    add(LB,                               6'b000000, 2'd2, 4);
    add(L,                                6'b001101, 2'd2, 5); // lu right after wait
    add(L,                                6'b111100, 2'd1, 6);
    add(IDLE,                             6'b111100, 2'd0, 6);

    cycle(RST); cycle(RST);
    foreach (tbl[i]) begin
      cycle(tbl[i].s);
      chk($sformatf("tbl%0d_out", i), 32'(a_out), 32'(tbl[i].exp_out));
      chk($sformatf("tbl%0d_hz", i), 32'(a_hz), 32'(tbl[i].exp_hz));
      chk($sformatf("tbl%0d_cnt", i), 32'(a_cnt), 32'(tbl[i].exp_cnt));
    end

    // Memory wait with load-use held: three freezes, then one bubble.
    cycle(RST);
    for (int i = 0; i < 3; i++) begin
      cycle(LB);
      chk("memwait_freeze", 32'(a_out), 32'h00);
    end
    cycle(L);
    chk("memwait_bubble", 32'(a_out), 32'(6'b001101));
    cycle(IDLE);
    chk("memwait_count", 32'(a_cnt), 32'd4);

    // Reset mid-LU_BUBBLE and mid-MEM_WAIT leaves nothing behind.
    cycle(RST); cycle(L); cycle(RST); cycle(IDLE);
    chk("rst_lu_out", 32'(a_out), 32'(6'b111100));
    chk("rst_lu_hz", 32'(a_hz), 32'd0);
    cycle(BUSY); cycle(BUSY); cycle(RST); cycle(IDLE);
    chk("rst_mw_out", 32'(a_out), 32'(6'b111100));
    chk("rst_mw_hz", 32'(a_hz), 32'd0);
    chk("rst_mw_cnt", 32'(a_cnt), 32'd0);

    // Timeout: set after the 64th busy edge, sticky, cleared by reset.
    cycle(RST);
    for (int i = 0; i < 63; i++) cycle(BUSY);
    cycle(BUSY);
    chk("timeout_at_63", 32'(a_to), 32'd0);
    cycle(IDLE);
    chk("timeout_at_64", 32'(a_to), 32'd1);
    cycle(IDLE); cycle(IDLE);
    chk("timeout_sticky", 32'(a_to), 32'd1);
    cycle(mk(1, 5, 0, 1, 0, 5, 1, 1, 1, 1));
    chk("rst_flush_all", 32'(a_out), 32'(6'b111111));
    cycle(IDLE);
    chk("rst_timeout", 32'(a_to), 32'd0);
    chk("rst_count", 32'(a_cnt), 32'd0);
    chk("rst_hz", 32'(a_hz), 32'd0);

    // Saturation of the 4-bit counter instance.
    cycle(RST);
    for (int i = 0; i < 20; i++) cycle(BUSY);
    cycle(IDLE);
    chk("sat_count4", 32'(a_cnt_sat), 32'd15);
    chk("sat_count16", 32'(a_cnt), 32'd20);

    // Randomized cycles against the model.
    for (int i = 0; i < 3000; i++) begin
      stim_t s;
      s.rst  = ($urandom_range(0, 99) == 0);
      s.rs   = 4'($urandom_range(0, 3));
      s.rt   = 4'($urandom_range(0, 3));
      s.urs  = 1'($urandom_range(0, 1));
      s.urt  = 1'($urandom_range(0, 1));
      s.rd   = 4'($urandom_range(0, 3));
      s.mr   = ($urandom_range(0, 2) != 0);
      s.wr   = ($urandom_range(0, 3) != 0);
      s.br   = ($urandom_range(0, 3) == 0);
      s.busy = ($urandom_range(0, 4) == 0);
      cycle(s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
